// File: rtl/wm_front_panel.sv
// Front panel for the WashingMachine core: debounces raw buttons into machine
// commands and decodes the machine state (cs) into panel state, error code and buzzer.
module wm_front_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMER_STEP      = 10,
    parameter int TIMER_MAX       = 300,
    parameter int TIMER_DEFAULT   = 100,
    parameter int NUM_MODES       = 7,
    parameter int BUZZ_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_power,
    input  logic        btn_start,
    input  logic        btn_mode,
    input  logic        btn_manual,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic [3:0]  cs,
    output logic        powerButton,
    output logic        configu,
    output logic        run,
    output logic [2:0]  mode,
    output logic [31:0] manualTimer,
    output logic [2:0]  panel_state,
    output logic [1:0]  err_code,
    output logic        buzzer
);

    localparam int NB       = 6;
    localparam int B_POWER  = 0;
    localparam int B_START  = 1;
    localparam int B_MANUAL = 2;
    localparam int B_MODE   = 3;
    localparam int B_UP     = 4;
    localparam int B_DN     = 5;

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BCW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0] BUZZ_LAST = BCW'(BUZZ_CYCLES - 1);
    localparam logic [31:0]    T_STEP    = 32'(TIMER_STEP);
    localparam logic [31:0]    T_MAX     = 32'(TIMER_MAX);
    localparam logic [31:0]    T_DEF     = 32'(TIMER_DEFAULT);
    localparam logic [2:0]     MODE_LAST = 3'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_SELECT  = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_ALERT   = 3'd4,
        S_DONE    = 3'd5
    } panel_e;

    // Bit order doubles as press priority: lower index wins.
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_dn, btn_up, btn_mode, btn_manual, btn_start, btn_power};

    logic [NB-1:0]  sync1_q, sync2_q, deb_q, deb_dly_q, press_q;
    logic [DCW-1:0] dcnt_q [NB];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < NB; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == DEB_LAST) begin
                        deb_q[i]  <= sync2_q[i];
                        dcnt_q[i] <= '0;
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + DCW'(1);
                    end
                end else begin
                    dcnt_q[i] <= '0;
                end
            end
        end
    end

    // Isolate the lowest set bit so only the highest-priority press acts.
    logic [NB-1:0] win;
    assign win = press_q & (~press_q + NB'(1));

    panel_e         state_q, state_d, ret_q, ret_d;
    logic [2:0]     mode_q, mode_d;
    logic           cfg_q, cfg_d, run_q, run_d, power_q, power_d, buzzer_q, buzzer_d;
    logic [31:0]    timer_q, timer_d;
    logic [BCW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic [1:0]     err_q, err_d;
    logic           cs_err, cs_done;

    assign cs_err  = (cs == 4'd8) || (cs == 4'd9);
    assign cs_done = (cs == 4'd7);

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        mode_d     = mode_q;
        cfg_d      = cfg_q;
        timer_d    = timer_q;
        run_d      = run_q;
        power_d    = power_q;
        buzz_cnt_d = buzz_cnt_q;
        buzzer_d   = buzzer_q;
        err_d      = 2'b00;
        case (state_q)
            S_OFF: begin
                run_d    = 1'b0;
                power_d  = 1'b0;
                buzzer_d = 1'b0;
                if (win[B_POWER]) begin
                    state_d = S_SELECT;
                    power_d = 1'b1;
                end
            end
            S_SELECT: begin
                buzzer_d = 1'b0;
                if (win[B_START]) begin
                    state_d = S_RUNNING;
                    run_d   = 1'b1;
                end else if (win[B_MANUAL]) begin
                    cfg_d = ~cfg_q;
                end else if (win[B_MODE]) begin
                    mode_d = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
                end else if (win[B_UP]) begin
                    timer_d = (timer_q > T_MAX - T_STEP) ? T_MAX : timer_q + T_STEP;
                end else if (win[B_DN]) begin
                    timer_d = (timer_q < T_STEP) ? 32'd0 : timer_q - T_STEP;
                end
            end
            S_RUNNING: begin
                if (cs_err) begin
                    state_d  = S_ALERT;
                    ret_d    = S_RUNNING;
                    buzzer_d = 1'b1;
                end else if (cs_done) begin
                    state_d    = S_DONE;
                    run_d      = 1'b0;
                    buzzer_d   = 1'b1;
                    buzz_cnt_d = '0;
                end else if (win[B_START]) begin
                    state_d = S_PAUSED;
                    run_d   = 1'b0;
                end
            end
            S_PAUSED: begin
                if (cs_err) begin
                    state_d  = S_ALERT;
                    ret_d    = S_PAUSED;
                    buzzer_d = 1'b1;
                end else if (win[B_START]) begin
                    state_d = S_RUNNING;
                    run_d   = 1'b1;
                end
            end
            S_ALERT: begin
                buzzer_d = 1'b1;
                if (!cs_err) begin
                    state_d  = ret_q;
                    buzzer_d = 1'b0;
                end
            end
            S_DONE: begin
                run_d = 1'b0;
                if (win[B_START] || buzz_cnt_q == BUZZ_LAST) begin
                    state_d  = S_SELECT;
                    buzzer_d = 1'b0;
                end else begin
                    buzz_cnt_d = buzz_cnt_q + BCW'(1);
                end
            end
            default: begin
                state_d  = S_OFF;
                run_d    = 1'b0;
                power_d  = 1'b0;
                buzzer_d = 1'b0;
            end
        endcase
        // Power press overrides everything else from any powered state.
        if (win[B_POWER] && state_q != S_OFF) begin
            state_d  = S_OFF;
            power_d  = 1'b0;
            run_d    = 1'b0;
            buzzer_d = 1'b0;
        end
        if (state_d != S_OFF) begin
            if (cs == 4'd8)      err_d = 2'b01;
            else if (cs == 4'd9) err_d = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            ret_q      <= S_RUNNING;
            mode_q     <= 3'd0;
            cfg_q      <= 1'b0;
            timer_q    <= T_DEF;
            run_q      <= 1'b0;
            power_q    <= 1'b0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            mode_q     <= mode_d;
            cfg_q      <= cfg_d;
            timer_q    <= timer_d;
            run_q      <= run_d;
            power_q    <= power_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
            err_q      <= err_d;
        end
    end

    assign powerButton = power_q;
    assign configu     = cfg_q;
    assign run         = run_q;
    assign mode        = mode_q;
    assign manualTimer = timer_q;
    assign panel_state = state_q;
    assign err_code    = err_q;
    assign buzzer      = buzzer_q;

endmodule

// File: tb/tb_wm_front_panel.sv
// Bench for wm_front_panel: randomized button presses checked against a
// press-level behavioural model of the panel, plus cycle-exact timing scenarios.
module tb_wm_front_panel;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_power = 1'b0, btn_start = 1'b0, btn_mode = 1'b0;
    logic        btn_manual = 1'b0, btn_up = 1'b0, btn_dn = 1'b0;
    logic [3:0]  cs = 4'd1;
    logic        powerButton, configu, run, buzzer;
    logic [2:0]  mode, panel_state;
    logic [31:0] manualTimer;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    // Press-level model of the panel settings.
    logic [2:0]  m_state, m_mode;
    logic        m_cfg, m_run, m_pow;
    logic [31:0] m_timer;

    wm_front_panel dut (
        .clk(clk), .rst_n(rst_n),
        .btn_power(btn_power), .btn_start(btn_start), .btn_mode(btn_mode),
        .btn_manual(btn_manual), .btn_up(btn_up), .btn_dn(btn_dn),
        .cs(cs),
        .powerButton(powerButton), .configu(configu), .run(run), .mode(mode),
        .manualTimer(manualTimer), .panel_state(panel_state),
        .err_code(err_code), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mask bits: 0 power, 1 start, 2 manual, 3 mode, 4 up, 5 dn
    task automatic set_btns(input logic [5:0] m);
        {btn_dn, btn_up, btn_mode, btn_manual, btn_start, btn_power} = m;
    endtask

    task automatic model_reset();
        m_state = 3'd0; m_mode = 3'd0; m_cfg = 1'b0;
        m_timer = 32'd100; m_run = 1'b0; m_pow = 1'b0;
    endtask

    task automatic model_press(input logic [5:0] m);
        if (m[0]) begin
            if (m_state == 3'd0) begin
                m_state = 3'd1; m_pow = 1'b1;
            end else begin
                m_state = 3'd0; m_pow = 1'b0; m_run = 1'b0;
            end
        end else if (m_state == 3'd0) begin
            m_state = 3'd0;
        end else if (m[1]) begin
            case (m_state)
                3'd1: begin m_state = 3'd2; m_run = 1'b1; end
                3'd2: begin m_state = 3'd3; m_run = 1'b0; end
                3'd3: begin m_state = 3'd2; m_run = 1'b1; end
                default: m_state = m_state;
            endcase
        end else if (m_state == 3'd1) begin
            if (m[2])      m_cfg = ~m_cfg;
            else if (m[3]) m_mode = (m_mode == 3'd6) ? 3'd0 : m_mode + 3'd1;
            else if (m[4]) m_timer = (m_timer + 32'd10 > 32'd300) ? 32'd300 : m_timer + 32'd10;
            else if (m[5]) m_timer = (m_timer < 32'd10) ? 32'd0 : m_timer - 32'd10;
        end
    endtask

    // Hold buttons, release, and wait long enough for the command to settle.
    task automatic press(input logic [5:0] m, input int hold);
        @(negedge clk);
        set_btns(m);
        repeat (hold) @(negedge clk);
        set_btns(6'd0);
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic do_press(input logic [5:0] m);
        press(m, $urandom_range(DEB + 1, DEB + 6));
        model_press(m);
    endtask

    task automatic goto_select();
        if (m_state != 3'd1) begin
            if (m_state != 3'd0) do_press(6'b000001);
            do_press(6'b000001);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({panel_state, mode, configu, manualTimer, run, powerButton} !==
            {3'd0, 3'd0, 1'b0, 32'd100, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got st=%0d mode=%0d cfg=%0b tmr=%0d run=%0b pwr=%0b, need 0 0 0 100 0 0",
                     panel_state, mode, configu, manualTimer, run, powerButton);
        end
        checks++;
        if ({err_code, buzzer} !== 3'b000) begin
            failures++;
            $display("FAIL reset_err_buzz: got err=%b buzz=%b, need 00 0", err_code, buzzer);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_power_timing();
        cs = 4'd1;
        @(negedge clk);
        btn_power = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1;
        checks++;
        if (powerButton !== 1'b0 || panel_state !== 3'd0) begin
            failures++;
            $display("FAIL power_early: got pwr=%b st=%0d, need 0 0", powerButton, panel_state);
        end
        @(posedge clk);
        #1;
        checks++;
        if (powerButton !== 1'b1 || panel_state !== 3'd1) begin
            failures++;
            $display("FAIL power_edge: got pwr=%b st=%0d, need 1 1", powerButton, panel_state);
        end
        repeat (2) @(negedge clk);
        btn_power = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        model_press(6'b000001);
        checks++;
        if ({panel_state, powerButton} !== {m_state, m_pow}) begin
            failures++;
            $display("FAIL power_hold_release: got st=%0d pwr=%b, need %0d %b",
                     panel_state, powerButton, m_state, m_pow);
        end
    endtask

    task automatic test_select();
        for (int i = 0; i < 8; i++) begin
            do_press(6'b001000);
            checks++;
            if (mode !== m_mode) begin
                failures++;
                $display("FAIL mode_step%0d: got %0d, need %0d", i, mode, m_mode);
            end
        end
        for (int i = 0; i < 31; i++) begin
            do_press(6'b010000);
            checks++;
            if (manualTimer !== m_timer) begin
                failures++;
                $display("FAIL timer_up%0d: got %0d, need %0d", i, manualTimer, m_timer);
            end
        end
        checks++;
        if (manualTimer !== 32'd300) begin
            failures++;
            $display("FAIL timer_sat_max: got %0d, need 300", manualTimer);
        end
        for (int i = 0; i < 40; i++) begin
            do_press(6'b100000);
            checks++;
            if (manualTimer !== m_timer) begin
                failures++;
                $display("FAIL timer_dn%0d: got %0d, need %0d", i, manualTimer, m_timer);
            end
        end
        checks++;
        if (manualTimer !== 32'd0) begin
            failures++;
            $display("FAIL timer_sat_zero: got %0d, need 0", manualTimer);
        end
        do_press(6'b000100);
        checks++;
        if (configu !== m_cfg) begin
            failures++;
            $display("FAIL manual_toggle: got %b, need %b", configu, m_cfg);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        btn_power = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn_power = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        // Held mode button with a short low dip must count as one press.
        btn_mode = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        btn_mode = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        btn_mode = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        btn_mode = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        model_press(6'b001000);
        checks++;
        if ({panel_state, mode, configu, manualTimer, run, powerButton} !==
            {m_state, m_mode, m_cfg, m_timer, m_run, m_pow}) begin
            failures++;
            $display("FAIL glitch: got st=%0d mode=%0d pwr=%b, need %0d %0d %b",
                     panel_state, mode, powerButton, m_state, m_mode, m_pow);
        end
    endtask

    task automatic test_priority();
        do_press(6'b111000);
        checks++;
        if ({mode, manualTimer} !== {m_mode, m_timer}) begin
            failures++;
            $display("FAIL prio_mode_up_dn: got mode=%0d tmr=%0d, need %0d %0d",
                     mode, manualTimer, m_mode, m_timer);
        end
        do_press(6'b001010);
        checks++;
        if ({panel_state, mode, run} !== {m_state, m_mode, m_run}) begin
            failures++;
            $display("FAIL prio_start_mode: got st=%0d mode=%0d run=%b, need %0d %0d %b",
                     panel_state, mode, run, m_state, m_mode, m_run);
        end
    endtask

    task automatic test_random();
        logic [5:0] m;
        for (int i = 0; i < 40; i++) begin
            cs = 4'($urandom_range(2, 6));
            m = {5'($urandom_range(1, 31)), 1'b0};
            if ($urandom_range(0, 9) == 0) m[0] = 1'b1;
            do_press(m);
            checks++;
            if ({panel_state, mode, configu, manualTimer, run, powerButton, err_code, buzzer} !==
                {m_state, m_mode, m_cfg, m_timer, m_run, m_pow, 2'b00, 1'b0}) begin
                failures++;
                $display("FAIL random%0d mask=%b: got st=%0d mode=%0d cfg=%b tmr=%0d run=%b pwr=%b err=%b bz=%b, need %0d %0d %b %0d %b %b 00 0",
                         i, m, panel_state, mode, configu, manualTimer, run, powerButton, err_code, buzzer,
                         m_state, m_mode, m_cfg, m_timer, m_run, m_pow);
            end
        end
        cs = 4'd1;
    endtask

    task automatic test_run_done();
        int n;
        goto_select();
        for (int k = 0; k < 8; k++) if (m_mode != 3'd2) do_press(6'b001000);
        do_press(6'b000010);
        checks++;
        if ({panel_state, run, mode} !== {3'd2, 1'b1, 3'd2}) begin
            failures++;
            $display("FAIL start_run: got st=%0d run=%b mode=%0d, need 2 1 2", panel_state, run, mode);
        end
        do_press(6'b001000);
        checks++;
        if (mode !== 3'd2) begin
            failures++;
            $display("FAIL mode_frozen: got %0d, need 2", mode);
        end
        @(negedge clk);
        cs = 4'd7;
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, run, buzzer} !== {3'd5, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL done_entry: got st=%0d run=%b bz=%b, need 5 0 1", panel_state, run, buzzer);
        end
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (buzzer !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 16 || panel_state !== 3'd1) begin
            failures++;
            $display("FAIL buzz_length: got %0d cycles st=%0d, need 16 1", n, panel_state);
        end
        @(negedge clk);
        cs = 4'd1;
        m_state = 3'd1;
        m_run = 1'b0;
    endtask

    task automatic test_done_ack();
        do_press(6'b000010);
        @(negedge clk);
        cs = 4'd7;
        @(posedge clk);
        @(negedge clk);
        cs = 4'd1;
        btn_start = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1;
        checks++;
        if ({panel_state, buzzer} !== {3'd5, 1'b1}) begin
            failures++;
            $display("FAIL ack_before: got st=%0d bz=%b, need 5 1", panel_state, buzzer);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, buzzer, run} !== {3'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ack_select: got st=%0d bz=%b run=%b, need 1 0 0", panel_state, buzzer, run);
        end
        @(negedge clk);
        btn_start = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        m_state = 3'd1;
        m_run = 1'b0;
    endtask

    task automatic test_alert();
        do_press(6'b000010);
        @(negedge clk);
        cs = 4'd8;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ({panel_state, err_code, buzzer, run} !== {3'd4, 2'b01, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL alert_door: got st=%0d err=%b bz=%b run=%b, need 4 01 1 1",
                     panel_state, err_code, buzzer, run);
        end
        @(negedge clk);
        cs = 4'd9;
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, err_code} !== {3'd4, 2'b10}) begin
            failures++;
            $display("FAIL alert_follow: got st=%0d err=%b, need 4 10", panel_state, err_code);
        end
        @(negedge clk);
        cs = 4'd3;
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, err_code, buzzer, run} !== {3'd2, 2'b00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL alert_return_run: got st=%0d err=%b bz=%b run=%b, need 2 00 0 1",
                     panel_state, err_code, buzzer, run);
        end
        do_press(6'b000010);
        @(negedge clk);
        cs = 4'd9;
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, err_code, buzzer, run} !== {3'd4, 2'b10, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL alert_water: got st=%0d err=%b bz=%b run=%b, need 4 10 1 0",
                     panel_state, err_code, buzzer, run);
        end
        @(negedge clk);
        cs = 4'd3;
        @(posedge clk);
        #1;
        checks++;
        if ({panel_state, buzzer, run} !== {3'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL alert_return_pause: got st=%0d bz=%b run=%b, need 3 0 0",
                     panel_state, buzzer, run);
        end
    endtask

    task automatic test_power_override();
        do_press(6'b000010);
        do_press(6'b000011);
        checks++;
        if ({panel_state, mode, configu, manualTimer, run, powerButton, buzzer} !==
            {m_state, m_mode, m_cfg, m_timer, m_run, m_pow, 1'b0}) begin
            failures++;
            $display("FAIL power_override: got st=%0d mode=%0d cfg=%b tmr=%0d run=%b pwr=%b, need %0d %0d %b %0d %b %b",
                     panel_state, mode, configu, manualTimer, run, powerButton,
                     m_state, m_mode, m_cfg, m_timer, m_run, m_pow);
        end
        @(negedge clk);
        cs = 4'd8;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_code !== 2'b00) begin
            failures++;
            $display("FAIL err_when_off: got %b, need 00", err_code);
        end
        @(negedge clk);
        cs = 4'd1;
        do_press(6'b000001);
        do_press(6'b000010);
        do_press(6'b000010);
        checks++;
        if ({panel_state, run} !== {3'd3, 1'b0}) begin
            failures++;
            $display("FAIL reach_paused: got st=%0d run=%b, need 3 0", panel_state, run);
        end
        @(negedge clk);
        rst_n = 1'b0;
        btn_start = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({panel_state, mode, configu, manualTimer, run, powerButton} !==
            {m_state, m_mode, m_cfg, m_timer, m_run, m_pow}) begin
            failures++;
            $display("FAIL reset_mid_pause: got st=%0d mode=%0d cfg=%b tmr=%0d run=%b pwr=%b, need 0 0 0 100 0 0",
                     panel_state, mode, configu, manualTimer, run, powerButton);
        end
        @(negedge clk);
        btn_start = 1'b0;
        rst_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_power_timing();
        test_select();
        test_glitch();
        test_priority();
        test_random();
        test_run_done();
        test_done_ack();
        test_alert();
        test_power_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
